store_merge_unit: RTL



---
 rtl/store_pkg.sv | 30 +++
 rtl/store_byte_merge.sv | 22 ++
 rtl/store_merge_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/store_pkg.sv
// Shared types and helpers for the store merge unit: FSM states, store
// control encodings and the request alignment check.
package store_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READ  = 2'b01,
    S_WRITE = 2'b10,
    S_FAULT = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    ST_SB   = 2'b00,
    ST_SH   = 2'b01,
    ST_SW   = 2'b10,
    ST_RSVD = 2'b11
  } st_ctrl_t;

  // True when the request cannot be serviced: reserved encoding, or an
  // access not naturally aligned to its size.
  function automatic logic is_misaligned(input st_ctrl_t ctrl, input logic [1:0] addr_lo);
    case (ctrl)
      ST_SB:   return 1'b0;
      ST_SH:   return addr_lo[0];
      ST_SW:   return addr_lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_byte_merge.sv
// Combinational lane merge: inserts the byte or halfword of a store into the
// word read back from memory; word stores pass the new data straight through.
module store_byte_merge
  import store_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  st_ctrl_t    control,
  input  logic [1:0]  addr_lo,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    case (control)
      ST_SB:   merged[{addr_lo, 3'b000} +: 8]     = new_data[7:0];
      ST_SH:   merged[{addr_lo[1], 4'b0000} +: 16] = new_data[15:0];
      default: merged = new_data;
    endcase
  end

endmodule

// File: rtl/store_merge_unit.sv
// Store path to a word-only data memory: sub-word stores do read-modify-write,
// word stores write directly. Optional fault path under STORE_MERGE_FAULT_EN.
module store_merge_unit
  import store_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [1:0]        st_control,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rd_data,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wr_data,
  output logic              st_done,
  output logic              st_fault
);

  state_t            state_q, state_d;
  st_ctrl_t          ctrl_in, ctrl_eff, ctrl_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [31:0]       merged;
  logic              accept;

  assign ctrl_in = st_ctrl_t'(st_control);
  assign accept  = st_valid && st_ready;

`ifdef STORE_MERGE_FAULT_EN
  assign ctrl_eff = ctrl_in;
`else
  // Without fault detection the reserved encoding behaves as a word store.
  assign ctrl_eff = (ctrl_in == ST_RSVD) ? ST_SW : ctrl_in;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: the request capture registers are deliberately not reset; they are
  // only consumed after a fresh accept has loaded them.
  always_ff @(posedge clk) begin
    if (accept) begin
      ctrl_q <= ctrl_eff;
      addr_q <= st_addr;
      data_q <= st_data;
    end
  end

  store_byte_merge u_merge (
    .old_word (mem_rd_data),
    .new_data (data_q),
    .control  (ctrl_q),
    .addr_lo  (addr_q[1:0]),
    .merged   (merged)
  );

  // NOTE: every output and the next state get a default first, so no path
  // through the case can infer a latch.
  always_comb begin
    state_d     = state_q;
    st_ready    = 1'b0;
    mem_addr    = '0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    st_done     = 1'b0;
    st_fault    = 1'b0;
    case (state_q)
      S_IDLE: begin
        st_ready = 1'b1;
        if (st_valid) begin
`ifdef STORE_MERGE_FAULT_EN
          if (is_misaligned(ctrl_eff, st_addr[1:0])) state_d = S_FAULT;
          else
`endif
          if (ctrl_eff == ST_SW) state_d = S_WRITE;
          else                   state_d = S_READ;
        end
      end
      S_READ: begin
        mem_rd_en = 1'b1;
        mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        state_d   = S_WRITE;
      end
      S_WRITE: begin
        mem_wr_en   = 1'b1;
        st_done     = 1'b1;
        mem_addr    = {addr_q[ADDR_W-1:2], 2'b00};
        mem_wr_data = merged;
        state_d     = S_IDLE;
      end
`ifdef STORE_MERGE_FAULT_EN
      S_FAULT: begin
        st_fault = 1'b1;
        state_d  = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    // Reset quiets the port immediately so an in-flight write is dropped.
    if (rst) begin
      st_ready    = 1'b0;
      mem_addr    = '0;
      mem_rd_en   = 1'b0;
      mem_wr_en   = 1'b0;
      mem_wr_data = '0;
      st_done     = 1'b0;
      st_fault    = 1'b0;
    end
  end

endmodule
